// File: rtl/disable_seq_ctrl.sv
// Copy sequencer with early return: up to DEPTH copies of src_data per run,
// terminated early by the exit condition (after the copy) or by kill (instead of it).
module disable_seq_ctrl #(
    parameter int   WIDTH    = 8,
    parameter int   DEPTH    = 4,
    parameter logic EXIT_POL = 1'b0,
    parameter int   CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src_data,
    input  logic             cond,
    input  logic             kill,
    output logic [WIDTH-1:0] dst_data,
    output logic [CW-1:0]    copy_cnt,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             killed
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_dst;
    logic [CW-1:0]    r_cnt;
    logic             r_aborted;
    logic             r_killed;

    logic             w_exit;
    logic [CW-1:0]    w_cnt_nxt;

    assign w_exit    = (cond == EXIT_POL);
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
            r_killed  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_cnt     <= '0;
                        r_aborted <= 1'b0;
                        r_killed  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // kill pre-empts the copy; the exit test only sees a completed copy
                    if (kill) begin
                        r_killed <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_dst <= src_data;
                        r_cnt <= w_cnt_nxt;
                        if (w_exit) begin
                            r_aborted <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_cnt_nxt == L_DEPTH) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dst_data = r_dst;
    assign copy_cnt = r_cnt;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign aborted  = r_aborted;
    assign killed   = r_killed;

    a_flags_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(r_aborted && r_killed));
    a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
        (r_cnt <= L_DEPTH));

endmodule

// File: tb/tb_disable_seq_ctrl.sv
// Randomised scoreboard bench for disable_seq_ctrl: each run's outcome is predicted
// from the per-cycle inputs and checked by a monitor when done pulses.
module tb_disable_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [W-1:0] dst;
        int           cnt;
        logic         ab;
        logic         kl;
        int           n;
    } exp_t;

    logic          clk, rst;
    logic          start, cond, kill;
    logic [W-1:0]  src_data;
    logic [W-1:0]  dst_data;
    logic [CW-1:0] copy_cnt;
    logic          busy, done, aborted, killed;

    logic          start1, cond1, kill1;
    logic [W-1:0]  dst1;
    logic [CW-1:0] cnt1;
    logic          busy1, done1, ab1, kl1;

    int checks = 0;
    int errors = 0;

    exp_t         exp_q[$];
    logic [W-1:0] m_dst;
    logic [W-1:0] s_arr[DEPTH];
    logic         c_arr[DEPTH];
    logic         k_arr[DEPTH];

    int   mon_busy;
    logic mon_prev_done;

    disable_seq_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .EXIT_POL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .src_data(src_data), .cond(cond),
        .kill(kill), .dst_data(dst_data), .copy_cnt(copy_cnt), .busy(busy),
        .done(done), .aborted(aborted), .killed(killed)
    );

    disable_seq_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .EXIT_POL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .src_data(src_data), .cond(cond1),
        .kill(kill1), .dst_data(dst1), .copy_cnt(cnt1), .busy(busy1),
        .done(done1), .aborted(ab1), .killed(kl1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input logic ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expected run per done pulse.
    initial begin
        exp_t e;
        mon_busy      = 0;
        mon_prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_busy      = 0;
                mon_prev_done = 1'b0;
            end else begin
                if (busy) mon_busy++;
                if (mon_prev_done) chk(done == 1'b0, "done_one_cycle", done, 0);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(dst_data == e.dst, "dst_data", dst_data, e.dst);
                        chk(int'(copy_cnt) == e.cnt, "copy_cnt", copy_cnt, e.cnt);
                        chk(aborted == e.ab, "aborted", aborted, e.ab);
                        chk(killed == e.kl, "killed", killed, e.kl);
                        chk(mon_busy == e.n, "busy_cycles", mon_busy, e.n);
                        chk(busy == 1'b0, "busy_in_done", busy, 0);
                    end
                    mon_busy = 0;
                end
                mon_prev_done = done;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start    = 1'b0;
            src_data = W'($urandom);
            cond     = 1'($urandom_range(0, 1));
            kill     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic fill_random();
        for (int j = 0; j < DEPTH; j++) begin
            s_arr[j] = W'($urandom);
            c_arr[j] = ($urandom_range(0, 3) != 0);
            k_arr[j] = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic run_txn(input logic hold);
        exp_t e;
        e.dst = m_dst; e.cnt = 0; e.ab = 1'b0; e.kl = 1'b0; e.n = 0;
        for (int j = 0; j < DEPTH; j++) begin
            e.n = j + 1;
            if (k_arr[j]) begin
                e.kl = 1'b1;
                break;
            end
            e.dst = s_arr[j];
            e.cnt++;
            if (c_arr[j] == 1'b0) begin
                e.ab = 1'b1;
                break;
            end
        end
        exp_q.push_back(e);

        start = 1'b1;
        @(posedge clk); #1;
        chk(busy == 1'b1, "start_busy", busy, 1);
        chk(copy_cnt == '0, "start_cnt_clear", copy_cnt, 0);
        chk(aborted == 1'b0, "start_aborted_clear", aborted, 0);
        chk(killed == 1'b0, "start_killed_clear", killed, 0);
        chk(dst_data == m_dst, "start_dst_hold", dst_data, m_dst);

        for (int j = 0; j < e.n; j++) begin
            start    = hold ? 1'b1 : 1'($urandom_range(0, 1));
            src_data = s_arr[j];
            cond     = c_arr[j];
            kill     = k_arr[j];
            @(posedge clk); #1;
        end
        start    = hold ? 1'b1 : 1'($urandom_range(0, 1));
        src_data = W'($urandom);
        cond     = 1'($urandom_range(0, 1));
        kill     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        chk(busy == 1'b0 && done == 1'b0, "back_to_idle", {busy, done}, 0);
        chk(dst_data == e.dst, "hold_dst", dst_data, e.dst);
        chk(int'(copy_cnt) == e.cnt, "hold_cnt", copy_cnt, e.cnt);
        chk(aborted == e.ab && killed == e.kl, "hold_flags", {aborted, killed}, {e.ab, e.kl});
        m_dst = e.dst;
    endtask

    task automatic set_run(input logic [W-1:0] s0, s1, s2, s3,
                           input logic [3:0] cv, input logic [3:0] kv);
        s_arr[0] = s0; s_arr[1] = s1; s_arr[2] = s2; s_arr[3] = s3;
        for (int j = 0; j < DEPTH; j++) begin
            c_arr[j] = cv[j];
            k_arr[j] = kv[j];
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cond = 1'b1; kill = 1'b0; src_data = '0;
        start1 = 1'b0; cond1 = 1'b0; kill1 = 1'b0;
        m_dst = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk(dst_data == '0 && copy_cnt == '0, "reset_data", {dst_data, copy_cnt}, 0);
        chk({busy, done, aborted, killed} == 4'b0, "reset_ctrl", {busy, done, aborted, killed}, 0);
        chk({dst1, cnt1, busy1, done1, ab1, kl1} == '0, "reset_dut1", {dst1, cnt1}, 0);

        // normal, early exit, kill with exit, tie on last copy (cv bit j = cond at copy j)
        set_run(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 4'b0000); run_txn(1'b0); idle(1);
        set_run(8'h5C, 8'hA5, 8'h77, 8'h88, 4'b1101, 4'b0000); run_txn(1'b0); idle(2);
        set_run(8'h3C, 8'hC3, 8'h99, 8'hAA, 4'b1011, 4'b0100); run_txn(1'b0); idle(1);
        set_run(8'h01, 8'h02, 8'h03, 8'h04, 4'b0111, 4'b0000); run_txn(1'b0); idle(1);

        // start held high: one run each, flags cleared at the next accepted start
        set_run(8'h10, 8'h20, 8'h30, 8'h40, 4'b0111, 4'b0000); run_txn(1'b1);
        set_run(8'h50, 8'h60, 8'h70, 8'h80, 4'b1111, 4'b0000); run_txn(1'b1);
        idle(2);

        // EXIT_POL=1 instance
        start1 = 1'b1; @(posedge clk); #1;
        start1 = 1'b0; src_data = 8'h5A; cond1 = 1'b1;
        @(posedge clk); #1;
        chk(done1 == 1'b1 && busy1 == 1'b0, "pol1_done", {done1, busy1}, 2);
        chk(int'(cnt1) == 1 && ab1 == 1'b1 && kl1 == 1'b0, "pol1_exit", {cnt1, ab1, kl1}, 6);
        chk(dst1 == 8'h5A, "pol1_dst", dst1, 8'h5A);
        @(posedge clk); #1;
        chk(done1 == 1'b0, "pol1_done_clear", done1, 0);
        start1 = 1'b1; @(posedge clk); #1;
        start1 = 1'b0; cond1 = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            src_data = W'(8'hE0 + j);
            @(posedge clk); #1;
        end
        chk(done1 == 1'b1 && int'(cnt1) == DEPTH && ab1 == 1'b0, "pol1_full",
            {done1, cnt1, ab1}, {1'b1, CW'(DEPTH), 1'b0});
        chk(dst1 == W'(8'hE0 + DEPTH - 1), "pol1_full_dst", dst1, 8'hE0 + DEPTH - 1);
        idle(2);

        // reset during RUN: no done, everything zero, next run normal
        start = 1'b1; @(posedge clk); #1;
        start = 1'b0; src_data = 8'hBE; cond = 1'b1; kill = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk({dst_data, copy_cnt, busy, done, aborted, killed} == '0, "rst_mid_run",
            {dst_data, copy_cnt, busy, done}, 0);
        rst = 1'b0;
        m_dst = '0;
        idle(2);
        set_run(8'hF1, 8'hF2, 8'hF3, 8'hF4, 4'b1111, 4'b0000); run_txn(1'b0);

        for (int r = 0; r < 40; r++) begin
            fill_random();
            run_txn($urandom_range(0, 3) == 0);
            idle($urandom_range(0, 2));
        end

        idle(4);
        chk(exp_q.size() == 0, "pending_runs", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
